// File: rtl/frame_receiver_pkg.sv
// frame_receiver_pkg
// Shared definitions for the serial frame receiver: FSM state encoding,
// default payload width and the idle level of the serial line.
package frame_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_DATA_BITS = 8;

  // Serial line rests high; a low sample in IDLE is a start bit.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/frame_receiver.sv
// frame_receiver
// Serial-to-parallel front end. It waits for a start bit on a strobed serial
// line, shifts in DATA_BITS payload bits LSB-first, then a parity bit, then
// checks the stop bit. A good frame is presented as a registered
// {parity, payload} word together with a one-cycle valid pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bit_valid    strobe; serial_in is sampled only when high
//   serial_in    serial line (idle high)
//   clear        synchronous abort back to IDLE (frame_data retained)
//   frame_data   [DATA_BITS] parity bit, [DATA_BITS-1:0] payload; last good frame
//   frame_valid  one-cycle pulse when frame_data updates
//   framing_err  one-cycle pulse when the stop bit is 0
//   busy         high whenever the FSM is not in IDLE
//   parity_err   pulses with frame_valid on a parity failure
//
// Build option: define FRAME_PARITY_CHECK_EN to enable the registered
// parity_err output; otherwise parity_err is tied low and parity is left to
// the downstream checker.
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 serial_in,
  input  logic                 clear,
  output logic [DATA_BITS:0]   frame_data,
  output logic                 frame_valid,
  output logic                 framing_err,
  output logic                 busy,
  output logic                 parity_err
);

  // A one-bit payload would give a zero-width counter; keep at least one bit.
  localparam int unsigned CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic ODD_BIT = 1'(PARITY_ODD);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DATA_BITS:0]     frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   framing_err_q, framing_err_d;
  logic                   parity_bad_s;

  // Parity over the whole captured frame compared with the configured sense.
  assign parity_bad_s = (^{par_q, shift_q}) != ODD_BIT;

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    framing_err_d = 1'b0;

    if (clear) begin
      // Abort wins over a same-cycle strobe; the partial frame is dropped.
      state_d = ST_IDLE;
      cnt_d   = '0;
      shift_d = '0;
      par_d   = 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (serial_in != LINE_IDLE) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d[cnt_q] = serial_in;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          par_d   = serial_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // A low stop bit is reported, never reinterpreted as a start bit.
          if (serial_in == LINE_IDLE) begin
            frame_data_d  = {par_q, shift_q};
            frame_valid_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      // No strobe: hold everything, pulses return low.
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifdef FRAME_PARITY_CHECK_EN
  logic parity_err_q;

  // Parity failure pulse, aligned with the frame_valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= frame_valid_d & parity_bad_s;
    end
  end

  assign parity_err = parity_err_q;
`else
  // Checking disabled: the parity sense only matters when the check exists.
  assign parity_err = ODD_BIT & parity_bad_s & 1'b0;
`endif

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign framing_err = framing_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver
// Directed bench for frame_receiver. Stimulus tasks push the expected pulse
// (good frame or framing error) into a queue; a monitor on the falling edge
// pops and compares whenever the DUT pulses frame_valid or framing_err.
module tb_frame_receiver;

  logic       clk;
  logic       rst_n;
  logic       bit_valid;
  logic       serial_in;
  logic       clear;
  logic [8:0] frame_data;
  logic       frame_valid;
  logic       framing_err;
  logic       busy;
  logic       parity_err;

  typedef struct {
    logic [1:0] kind;   // {frame_valid, framing_err}
    logic [8:0] data;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  frame_receiver #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .serial_in   (serial_in),
    .clear       (clear),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .framing_err (framing_err),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [8:0] d);
`ifdef FRAME_PARITY_CHECK_EN
    return (^d) != 1'b0;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b1;
    serial_in = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    serial_in = 1'b1;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // exp is the hand-computed frame_data after the frame (retained value on a bad stop).
  task automatic send_frame(input logic [7:0] payload, input logic par, input logic stop,
                            input logic [8:0] exp, input int gap);
    exp_t e;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(payload[i], gap);
    send_bit(par, gap);
    e.kind = stop ? 2'b10 : 2'b01;
    e.data = exp;
    e.perr = stop ? exp_perr(exp) : 1'b0;
    exp_q.push_back(e);
    send_bit(stop, gap);
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (frame_valid || framing_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, frame_valid, framing_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", {30'd0, frame_valid, framing_err}, {30'd0, e.kind});
        chk("frame_data", {23'd0, frame_data}, {23'd0, e.data});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    serial_in = 1'b1;
    clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_data", {23'd0, frame_data}, 32'd0);
    chk("rst_pulses", {29'd0, frame_valid, framing_err, parity_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a frame.
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_outputs", {20'd0, frame_data, frame_valid, framing_err, parity_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(8'h34, 1'b1, 1'b1, 9'b100110100, 0);
    send_frame(8'h35, 1'b1, 1'b1, 9'b100110101, 0);
    send_frame(8'h35, 1'b0, 1'b1, 9'b000110101, 0);
    // Bad stop bit: frame_data keeps the previous good word.
    send_frame(8'hA5, 1'b0, 1'b0, 9'b000110101, 0);
    chk("busy_after_ferr", {31'd0, busy}, 32'd0);
    // Strobe gaps do not change the result.
    send_frame(8'h0F, 1'b0, 1'b1, 9'h00F, 3);

    // Clear together with the parity-bit strobe.
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(i[0], 0);
    bit_valid = 1'b1;
    clear     = 1'b1;
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    clear     = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd0);
    chk("clear_pulses", {30'd0, frame_valid, framing_err}, 32'd0);
    chk("clear_keeps_data", {23'd0, frame_data}, 32'h00F);
    // Idle-level bits after the abort must not complete a frame.
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    chk("idle_after_clear", {31'd0, busy}, 32'd0);

    // Back-to-back frames with no idle strobe between them.
    send_frame(8'hC3, 1'b0, 1'b1, 9'h0C3, 0);
    send_frame(8'h01, 1'b1, 1'b1, 9'h101, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
Serial-to-parallel front end that sits directly upstream of parityErrorChecker. It detects a start bit on a strobed serial line, shifts in DATA_BITS payload bits LSB-first, then one parity bit, then checks the stop bit. It presents each good frame as a registered {parity, payload} word plus a one-cycle valid pulse. The 9-bit output (default) wires straight into parityErrorChecker's data input.

Parameters:
DATA_BITS, 8, payload bits per frame; frame_data width = DATA_BITS+1
PARITY_ODD, 0, used only with FRAME_PARITY_CHECK_EN; 0 = even parity over the frame (total count of ones even), 1 = odd

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bit_valid  input  1  strobe: serial_in is sampled only in cycles where this is 1
serial_in  input  1  serial line bit; idle level 1
clear  input  1  synchronous abort; returns the FSM to IDLE
frame_data  output  DATA_BITS+1  [DATA_BITS] = parity bit, [DATA_BITS-1:0] = payload; holds the last good frame
frame_valid  output  1  one-cycle pulse when frame_data updates
framing_err  output  1  one-cycle pulse when the stop bit is 0
busy  output  1  high in any state other than IDLE
parity_err  output  1  see Optional Feature

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0, shift register=0, frame_data=0, frame_valid=0, framing_err=0, parity_err=0, busy=0.
- States are IDLE, DATA, PARITY, STOP. All transitions happen only in cycles with bit_valid=1. Cycles with bit_valid=0 leave all state unchanged.
- IDLE: serial_in=0 is the start bit → DATA with count=0. serial_in=1 → stay in IDLE.
- DATA: shift serial_in into payload bit [count] (LSB first) and increment count. When count reaches DATA_BITS-1, go to PARITY.
- PARITY: capture serial_in as the parity bit → STOP.
- STOP, serial_in=1: on the next clock edge, frame_data <= {parity, payload} and frame_valid=1 for exactly one cycle → IDLE.
- STOP, serial_in=0: framing_err=1 for one cycle. frame_data is unchanged and frame_valid stays 0 → IDLE. A 0 stop bit is not treated as a new start bit.
- Latency: frame_valid rises on the clock edge that samples the stop bit. There are no back-to-back restrictions, so a new start bit may arrive on the next bit_valid.
- clear=1: the FSM goes to IDLE and partial data is discarded. frame_data is retained. Pulse outputs are 0 in that cycle. clear takes priority over bit_valid in the same cycle.
- Reset mid-frame: the partial frame is lost and the IDLE-entry conditions above apply.
- frame_data changes only on good frames, so a downstream parityErrorChecker always sees a stable word.
- Counter width is $clog2(DATA_BITS). No wrap can occur because the exit happens at DATA_BITS-1.

Optional Feature:
- Macro: FRAME_PARITY_CHECK_EN.
- When defined: parity_err is registered. It pulses together with frame_valid when the XOR of the 9 bits (payload and parity bit) is not equal to PARITY_ODD. frame_data is still updated on a parity failure.
- When undefined: parity_err is tied to 0 and parity checking is left entirely to the downstream parityErrorChecker.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3);
  - the default DATA_BITS;
  - the idle-line level constant.
- No sub-module is needed. The single FSM plus shift register stays in one module.
- The parity XOR reduction is one expression and does not warrant its own module.

Test Plan:
- Reset mid-frame: assert rst_n=0 after 3 data bits → all outputs 0 immediately. Then a full frame of payload 8'h34 with parity 1 → frame_valid pulse, frame_data=9'b100110100.
- Good frame: start, payload 8'h35 (bits 1,0,1,0,1,1,0,0), parity 1, stop 1 → frame_valid high for one cycle, frame_data=9'b100110101, framing_err=0. With FRAME_PARITY_CHECK_EN and PARITY_ODD=0, parity_err=1.
- Same frame with parity 0 → frame_data=9'b000110101 and parity_err=0 when the feature is enabled.
- Framing error: start, payload 8'hA5, parity 0, stop 0 → framing_err pulses for one cycle, frame_valid=0, frame_data keeps its previous value, busy=0 afterwards.
- Gaps and clear: insert bit_valid=0 gaps of 3 cycles between bits of 8'h0F → same result as without gaps. Assert clear together with bit_valid in the PARITY state → IDLE, no pulses, frame_data unchanged.
